// File: rtl/motor_ramp_ctrl.sv
// Command stage in front of the PWM motor driver: accepts en/speed/direction
// targets over valid/ready, slews speed at a fixed rate and sequences
// direction reversals through a coast dead time.
module motor_ramp_ctrl #(
  parameter int unsigned TICK_DIV       = 1000,
  parameter int unsigned STEP           = 4,
  parameter int unsigned DEADTIME_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_en,
  input  logic [7:0] cmd_speed,
  input  logic       cmd_dir,
  input  logic       stop,
  output logic       en,
  output logic [7:0] speed,
  output logic       direction,
  output logic       at_target,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DW = (DEADTIME_TICKS > 1) ? $clog2(DEADTIME_TICKS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME_TICKS - 1);
  localparam logic [8:0]    STEP9     = 9'(STEP);

  typedef enum logic [1:0] {S_OFF, S_RUN, S_DEAD} state_t;

  state_t        state, state_n;
  logic [PW-1:0] prescaler;
  logic [DW-1:0] dead_cnt, dead_cnt_n;
  logic          tgt_en, tgt_en_n;
  logic [7:0]    tgt_speed, tgt_speed_n;
  logic          tgt_dir, tgt_dir_n;
  logic          en_n, dir_n, at_target_n;
  logic [7:0]    speed_n;
  logic          tick, accept, to_zero;
  logic [7:0]    eff_target, down_gap, slewed;
  logic [8:0]    up_sum;

  assign cmd_ready = !stop;
  assign accept    = cmd_valid && cmd_ready;
  assign tick      = (prescaler == PRE_LAST);
  assign busy      = !at_target;

  // Free-running ramp prescaler; tick marks its last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + 1'b1;
  end

  // One slew step toward the effective target, saturating at the target.
  always_comb begin
    to_zero    = !tgt_en || (tgt_dir != direction);
    eff_target = to_zero ? '0 : tgt_speed;
    up_sum     = {1'b0, speed} + STEP9;
    down_gap   = speed - eff_target;
    slewed     = speed;
    if (speed < eff_target) begin
      slewed = (up_sum >= {1'b0, eff_target}) ? eff_target : up_sum[7:0];
    end else if ({1'b0, down_gap} <= STEP9) begin
      slewed = eff_target;
    end else begin
      slewed = speed - STEP9[7:0];
    end
  end

  // Next-state, output and target-register logic; stop overrides everything.
  always_comb begin
    state_n     = state;
    en_n        = en;
    speed_n     = speed;
    dir_n       = direction;
    dead_cnt_n  = dead_cnt;
    tgt_en_n    = tgt_en;
    tgt_speed_n = tgt_speed;
    tgt_dir_n   = tgt_dir;
    if (stop) begin
      state_n  = S_OFF;
      en_n     = 1'b0;
      speed_n  = '0;
      tgt_en_n = 1'b0;
    end else begin
      case (state)
        S_OFF: begin
          en_n    = 1'b0;
          speed_n = '0;
          if (tgt_en) begin
            dir_n   = tgt_dir;
            en_n    = 1'b1;
            state_n = S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (to_zero && (speed == '0)) begin
              en_n = 1'b0;
              if (!tgt_en) begin
                state_n = S_OFF;
              end else begin
                state_n    = S_DEAD;
                dead_cnt_n = '0;
              end
            end else begin
              speed_n = slewed;
            end
          end
        end
        S_DEAD: begin
          en_n    = 1'b0;
          speed_n = '0;
          if (!tgt_en) begin
            state_n = S_OFF;
          end else if (tick) begin
            // Leaving on the tick that would bring the count to DEADTIME_TICKS.
            if (dead_cnt == DEAD_LAST) begin
              dir_n   = tgt_dir;
              en_n    = 1'b1;
              state_n = S_RUN;
            end else begin
              dead_cnt_n = dead_cnt + 1'b1;
            end
          end
        end
        default: state_n = S_OFF;
      endcase
      if (accept) begin
        tgt_en_n    = cmd_en;
        tgt_speed_n = cmd_speed;
        tgt_dir_n   = cmd_dir;
      end
    end
    // Registered flag evaluated on the values being loaded this edge.
    at_target_n = ((state_n == S_OFF) && !tgt_en_n) ||
                  ((state_n == S_RUN) && tgt_en_n &&
                   (speed_n == tgt_speed_n) && (dir_n == tgt_dir_n));
  end

  // State, outputs and target registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_OFF;
      en        <= 1'b0;
      speed     <= '0;
      direction <= 1'b0;
      dead_cnt  <= '0;
      tgt_en    <= 1'b0;
      tgt_speed <= '0;
      tgt_dir   <= 1'b0;
      at_target <= 1'b1;
    end else begin
      state     <= state_n;
      en        <= en_n;
      speed     <= speed_n;
      direction <= dir_n;
      dead_cnt  <= dead_cnt_n;
      tgt_en    <= tgt_en_n;
      tgt_speed <= tgt_speed_n;
      tgt_dir   <= tgt_dir_n;
      at_target <= at_target_n;
    end
  end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: behavioural reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_motor_ramp_ctrl;

  localparam int TD = 4;
  localparam int ST = 10;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_en = 1'b0;
  logic [7:0] cmd_speed = '0;
  logic       cmd_dir = 1'b0;
  logic       stop = 1'b0;
  logic       cmd_ready, en, direction, at_target, busy;
  logic [7:0] speed;

  int checks = 0;
  int errors = 0;

  motor_ramp_ctrl #(.TICK_DIV(TD), .STEP(ST), .DEADTIME_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_en(cmd_en), .cmd_speed(cmd_speed), .cmd_dir(cmd_dir), .stop(stop),
    .en(en), .speed(speed), .direction(direction), .at_target(at_target),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 = off, 1 = running, 2 = coasting before a flip.
  int m_pre, m_mode, m_dead, m_spd, m_tspd, goal, diff;
  bit m_en, m_dir, m_ten, m_tdir, m_at, m_last_tick, tk, reverse_or_off;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pre = 0; m_mode = 0; m_dead = 0; m_spd = 0; m_tspd = 0;
      m_en = 0; m_dir = 0; m_ten = 0; m_tdir = 0; m_at = 1; m_last_tick = 0;
    end else begin
      tk = (m_pre == TD - 1);
      m_last_tick = tk;
      m_pre = (m_pre + 1) % TD;
      if (stop) begin
        m_mode = 0; m_en = 0; m_spd = 0; m_ten = 0;
      end else begin
        if (m_mode == 0) begin
          if (m_ten) begin m_dir = m_tdir; m_en = 1; m_mode = 1; end
        end else if (m_mode == 1) begin
          if (tk) begin
            reverse_or_off = !(m_ten && (m_tdir == m_dir));
            goal = reverse_or_off ? 0 : m_tspd;
            if (reverse_or_off && m_spd == 0) begin
              m_en = 0; m_dead = 0;
              m_mode = m_ten ? 2 : 0;
            end else begin
              diff = goal - m_spd;
              if (diff > ST)       m_spd = m_spd + ST;
              else if (diff < -ST) m_spd = m_spd - ST;
              else                 m_spd = goal;
            end
          end
        end else begin
          if (!m_ten) m_mode = 0;
          else if (tk) begin
            m_dead++;
            if (m_dead >= DT) begin m_dir = m_tdir; m_en = 1; m_mode = 1; end
          end
        end
        if (cmd_valid) begin
          m_ten = cmd_en; m_tspd = int'(cmd_speed); m_tdir = cmd_dir;
        end
      end
      m_at = (m_mode == 0 && !m_ten) ||
             (m_mode == 1 && m_ten && m_spd == m_tspd && m_dir == m_tdir);
    end
  end

  // Compare DUT against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      chk("model_en", 32'(en), 32'(m_en));
      chk("model_speed", 32'(speed), 32'(m_spd));
      chk("model_dir", 32'(direction), 32'(m_dir));
      chk("model_at_target", 32'(at_target), 32'(m_at));
      chk("busy_inv", 32'(busy), 32'(!m_at));
      chk("cmd_ready", 32'(cmd_ready), 32'(!stop));
    end
  end

  task automatic step_clk();
    @(posedge clk); #1;
  endtask

  task automatic next_tick();
    for (int i = 0; i < 2 * TD; i++) begin
      @(posedge clk); #1;
      if (m_last_tick) return;
    end
    checks++; errors++;
    $display("FAIL tick_wait: got no tick expected one within %0d cycles", 2 * TD);
  endtask

  task automatic send(input logic e, input logic [7:0] s, input logic d);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_en = e; cmd_speed = s; cmd_dir = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_en", 32'(en), 0);
    chk("rst_speed", 32'(speed), 0);
    chk("rst_dir", 32'(direction), 0);
    @(negedge clk); @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_at_target", 32'(at_target), 1);

    // Ramp up from off
    send(1'b1, 8'd35, 1'b0);
    chk("s2_en_at_accept", 32'(en), 0);
    step_clk();
    chk("s2_en_latency", 32'(en), 1);
    next_tick(); chk("s2_speed10", 32'(speed), 10);
    next_tick(); chk("s2_speed20", 32'(speed), 20);
    next_tick(); chk("s2_speed30", 32'(speed), 30);
    next_tick(); chk("s2_speed35", 32'(speed), 35);
    chk("s2_at_target", 32'(at_target), 1);

    // Reversal
    send(1'b1, 8'd20, 1'b1);
    next_tick(); chk("s3_speed25", 32'(speed), 25);
    next_tick(); chk("s3_speed15", 32'(speed), 15);
    next_tick(); chk("s3_speed5", 32'(speed), 5);
    next_tick(); chk("s3_speed0", 32'(speed), 0);
    chk("s3_en_still", 32'(en), 1);
    next_tick(); chk("s3_coast_en", 32'(en), 0);
    chk("s3_coast_busy", 32'(busy), 1);
    next_tick(); next_tick();
    chk("s3_coast_dir", 32'(direction), 0);
    chk("s3_coast_en2", 32'(en), 0);
    next_tick();
    chk("s3_flip_dir", 32'(direction), 1);
    chk("s3_flip_en", 32'(en), 1);
    next_tick(); chk("s3_speed10", 32'(speed), 10);
    next_tick(); chk("s3_speed20", 32'(speed), 20);
    chk("s3_at_target", 32'(at_target), 1);

    // Emergency stop
    send(1'b1, 8'd100, 1'b1);
    stop = 1'b1;
    step_clk();
    chk("s4_speed", 32'(speed), 0);
    chk("s4_en", 32'(en), 0);
    chk("s4_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_en = 1'b1; cmd_speed = 8'd50; cmd_dir = 1'b1;
    step_clk(); step_clk();
    cmd_valid = 1'b0;
    step_clk();
    stop = 1'b0;
    next_tick(); next_tick(); next_tick();
    chk("s4_after_en", 32'(en), 0);
    chk("s4_after_speed", 32'(speed), 0);
    chk("s4_after_at", 32'(at_target), 1);

    // Ramp down to off
    send(1'b1, 8'd35, 1'b1);
    step_clk();
    chk("s5_en", 32'(en), 1);
    for (int i = 0; i < 4; i++) next_tick();
    chk("s5_speed35", 32'(speed), 35);
    send(1'b0, 8'd0, 1'b1);
    next_tick(); chk("s5_speed25", 32'(speed), 25);
    next_tick(); chk("s5_speed15", 32'(speed), 15);
    next_tick(); chk("s5_speed5", 32'(speed), 5);
    next_tick(); chk("s5_speed0", 32'(speed), 0);
    chk("s5_en_still", 32'(en), 1);
    next_tick(); chk("s5_off_en", 32'(en), 0);
    chk("s5_off_at", 32'(at_target), 1);

    // Clamp at the top of the range
    send(1'b1, 8'd250, 1'b1);
    step_clk();
    for (int i = 0; i < 25; i++) next_tick();
    chk("s6_speed250", 32'(speed), 250);
    send(1'b1, 8'd255, 1'b1);
    next_tick(); chk("s6_speed255", 32'(speed), 255);
    chk("s6_at_target", 32'(at_target), 1);

    // Overwrite target mid-ramp
    stop = 1'b1; step_clk(); stop = 1'b0;
    send(1'b1, 8'd200, 1'b1);
    step_clk();
    next_tick(); next_tick(); next_tick();
    chk("s6_speed30", 32'(speed), 30);
    send(1'b1, 8'd40, 1'b1);
    next_tick(); chk("s6_speed40", 32'(speed), 40);
    next_tick(); chk("s6_hold40", 32'(speed), 40);
    chk("s6_hold_at", 32'(at_target), 1);

    // Reset mid-ramp
    send(1'b1, 8'd100, 1'b1);
    next_tick(); next_tick();
    #2 rst = 1'b1;
    #1;
    chk("s1_mid_en", 32'(en), 0);
    chk("s1_mid_speed", 32'(speed), 0);
    chk("s1_mid_dir", 32'(direction), 0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("s1_rel_ready", 32'(cmd_ready), 1);
    chk("s1_rel_at", 32'(at_target), 1);
    repeat (6) step_clk();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
